// File: rtl/axis_crc32_mpeg2_checker_if.sv
// AXI-Stream bundle (tvalid/tready/tdata) with slave-side and master-side views.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport s_axis (input tvalid, input tdata, output tready);
    modport m_axis (output tvalid, output tdata, input tready);
endinterface

// File: rtl/axis_crc32_mpeg2_checker.sv
// Receive-side CRC32/MPEG-2 checker: forwards FRAME_BEATS payload beats, strips the
// 32-bit trailer and pulses crc_valid with crc_err once per completed frame.
package axis_crc32_mpeg2_pkg_prm;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
endpackage

module axis_crc32_mpeg2_checker #(
    parameter int unsigned DATA_WIDTH  = axis_crc32_mpeg2_pkg_prm::AXI_DATA_WIDTH,
    parameter int unsigned FRAME_BEATS = 16
) (
    input  logic        aclk,
    input  logic        areset,
    axis_if.s_axis      s_axis,
    axis_if.m_axis      m_axis,
    output logic        crc_valid,
    output logic        crc_err,
    output logic [15:0] frame_cnt
);
    import axis_crc32_mpeg2_pkg_prm::*;

    localparam int unsigned CRC_BEATS = 32 / DATA_WIDTH;
    localparam int unsigned MAX_BEATS = (FRAME_BEATS > CRC_BEATS) ? FRAME_BEATS : CRC_BEATS;
    localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_BEATS - 1);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
        $error("axis_crc32_mpeg2_checker: DATA_WIDTH must be 8, 16 or 32");
    end
    if (FRAME_BEATS == 0) begin : g_bad_frame
        $error("axis_crc32_mpeg2_checker: FRAME_BEATS must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           crc_q, crc_d;
    logic [31:0]           trailer_q, trailer_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  crc_valid_q, crc_valid_d;
    logic                  crc_err_q, crc_err_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  s_ready_c;
    logic [31:0]           trailer_shift_c;

    // Bit-serial MSB-first CRC over one beat; the top byte of the beat goes in first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic [DATA_WIDTH-1:0] data);
        logic [31:0]           c;
        logic [DATA_WIDTH-1:0] d;
        c = crc;
        d = data;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            c = (c[31] ^ d[DATA_WIDTH-1]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
            d = d << 1;
        end
        return c;
    endfunction

    assign trailer_shift_c = 32'({trailer_q, s_axis.tdata});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        trailer_d   = trailer_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        crc_valid_d = 1'b0;
        crc_err_d   = crc_err_q;
        frame_cnt_d = frame_cnt_q;
        s_ready_c   = 1'b1;

        if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_DATA: begin
                s_ready_c = !tvalid_q || m_axis.tready;
                if (s_axis.tvalid && s_ready_c) begin
                    tdata_d  = s_axis.tdata;
                    tvalid_d = 1'b1;
                    crc_d    = crc_step(crc_q, s_axis.tdata);
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = ST_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (s_axis.tvalid) begin
                    trailer_d = trailer_shift_c;
                    // Verdict lands with the re-armed CRC so the next payload beat needs no bubble.
                    if (cnt_q == LAST_CRC) begin
                        cnt_d       = '0;
                        state_d     = ST_DATA;
                        crc_valid_d = 1'b1;
                        crc_err_d   = (trailer_shift_c != crc_q);
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        crc_d       = CRC_INIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_DATA;
            cnt_q       <= '0;
            crc_q       <= CRC_INIT;
            trailer_q   <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            trailer_q   <= trailer_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            crc_valid_q <= crc_valid_d;
            crc_err_q   <= crc_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_axis.tready = s_ready_c;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign crc_valid     = crc_valid_q;
    assign crc_err       = crc_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_crc32_mpeg2_checker.sv
// Directed bench: byte-wide 9-beat instance for the "123456789" vectors, word-wide
// 4-beat instance for randomised gaps/stalls against a byte-serial CRC model.
module tb_axis_crc32_mpeg2_checker;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic aclk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 aclk = ~aclk;

    axis_if #(.DATA_WIDTH(8))  sa ();
    axis_if #(.DATA_WIDTH(8))  ma ();
    axis_if #(.DATA_WIDTH(32)) sb ();
    axis_if #(.DATA_WIDTH(32)) mb ();

    logic        cv_a, err_a, cv_b, err_b;
    logic [15:0] fc_a, fc_b;

    axis_crc32_mpeg2_checker #(.DATA_WIDTH(8), .FRAME_BEATS(9)) dut_a (
        .aclk      (aclk),
        .areset    (rst_a),
        .s_axis    (sa),
        .m_axis    (ma),
        .crc_valid (cv_a),
        .crc_err   (err_a),
        .frame_cnt (fc_a)
    );

    axis_crc32_mpeg2_checker #(.DATA_WIDTH(32), .FRAME_BEATS(4)) dut_b (
        .aclk      (aclk),
        .areset    (rst_b),
        .s_axis    (sb),
        .m_axis    (mb),
        .crc_valid (cv_b),
        .crc_err   (err_b),
        .frame_cnt (fc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          cv_cnt_a    = 0;
    int          cv_cnt_b    = 0;
    int          err_cnt_b   = 0;
    logic        prev_cv_a   = 1'b0;
    logic        prev_cv_b   = 1'b0;
    logic        stall_b     = 1'b0;
    logic [31:0] hold_data_b = '0;
    logic [31:0] qb_out [$];
    logic [31:0] exp_b  [$];
    bit          rand_rdy    = 1'b0;

    logic [7:0] good_f [13];
    logic [7:0] bad_f  [13];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] w [4]);
        logic [31:0] c;
        logic [7:0]  by;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            for (int b = 3; b >= 0; b--) begin
                by = w[k][8*b +: 8];
                c  = c ^ {by, 24'h0};
                for (int j = 0; j < 8; j++) begin
                    c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
                end
            end
        end
        return c;
    endfunction

    task automatic send_a(input logic [7:0] d, output int cyc);
        logic hs;
        sa.tvalid = 1'b1;
        sa.tdata  = d;
        cyc = 0;
        hs  = 1'b0;
        while (!hs && cyc < 50) begin
            @(negedge aclk);
            hs = sa.tready;
            @(posedge aclk);
            #1;
            cyc++;
        end
        check("a_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_b(input logic [31:0] d);
        logic hs;
        int   cyc;
        sb.tvalid = 1'b1;
        sb.tdata  = d;
        cyc = 0;
        hs  = 1'b0;
        while (!hs && cyc < 200) begin
            @(negedge aclk);
            hs = sb.tready;
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (!hs) check("b_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_frame_a(input logic [7:0] f [13], input bit chk, output int cycles);
        int c;
        cycles = 0;
        for (int i = 0; i < 13; i++) begin
            send_a(f[i], c);
            cycles += c;
            if (chk) begin
                if (i < 9) begin
                    check("a_out_valid", 32'(ma.tvalid), 32'd1);
                    check("a_out_data", 32'(ma.tdata), 32'(f[i]));
                end else begin
                    check("a_trailer_not_fwd", 32'(ma.tvalid), 32'd0);
                end
                if (i < 12) check("a_no_early_cv", 32'(cv_a), 32'd0);
            end
        end
    endtask

    // Output-side observers: pulse counting, stall stability and the B payload stream.
    always @(negedge aclk) begin
        if (cv_a) begin
            check("a_cv_back_to_back", 32'(prev_cv_a), 32'd0);
            cv_cnt_a <= cv_cnt_a + 1;
        end
        prev_cv_a <= cv_a;
        if (cv_b) begin
            check("b_cv_back_to_back", 32'(prev_cv_b), 32'd0);
            cv_cnt_b <= cv_cnt_b + 1;
            if (err_b) err_cnt_b <= err_cnt_b + 1;
        end
        prev_cv_b <= cv_b;
        if (stall_b) begin
            check("b_stall_valid", 32'(mb.tvalid), 32'd1);
            check("b_stall_data", mb.tdata, hold_data_b);
        end
        if (mb.tvalid && mb.tready) qb_out.push_back(mb.tdata);
        stall_b     <= mb.tvalid && !mb.tready;
        hold_data_b <= mb.tdata;
    end

    initial begin
        mb.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            mb.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int          cyc;
        int          tot;
        logic [31:0] w [4];
        logic [31:0] crc;

        good_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h03, 8'h76, 8'hE6, 8'hE7};
        bad_f    = good_f;
        bad_f[5] = 8'h00;

        rst_a = 1'b1;
        rst_b = 1'b1;
        sa.tvalid = 1'b0;
        sa.tdata  = '0;
        ma.tready = 1'b1;
        sb.tvalid = 1'b0;
        sb.tdata  = '0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_rst_tvalid", 32'(ma.tvalid), 32'd0);
        check("a_rst_tdata", 32'(ma.tdata), 32'd0);
        check("a_rst_cv", 32'(cv_a), 32'd0);
        check("a_rst_err", 32'(err_a), 32'd0);
        check("a_rst_fc", 32'(fc_a), 32'd0);
        check("a_rst_sready", 32'(sa.tready), 32'd1);
        check("b_rst_tvalid", 32'(mb.tvalid), 32'd0);
        check("b_rst_fc", 32'(fc_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge aclk);
        #1;

        // Check vector "123456789" with trailer 0x0376E6E7.
        send_frame_a(good_f, 1'b1, tot);
        check("t1_cv", 32'(cv_a), 32'd1);
        check("t1_err", 32'(err_a), 32'd0);
        check("t1_fc", 32'(fc_a), 32'd1);
        check("t1_cycles", 32'(tot), 32'd13);
        sa.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        check("t1_cv_one_cycle", 32'(cv_a), 32'd0);

        // Corrupted frame, then a clean one with no idle cycle in between.
        send_frame_a(bad_f, 1'b1, cyc);
        tot = cyc;
        check("t2_bad_cv", 32'(cv_a), 32'd1);
        check("t2_bad_err", 32'(err_a), 32'd1);
        check("t2_bad_fc", 32'(fc_a), 32'd2);
        send_frame_a(good_f, 1'b1, cyc);
        tot += cyc;
        check("t2_good_cv", 32'(cv_a), 32'd1);
        check("t2_good_err", 32'(err_a), 32'd0);
        check("t2_good_fc", 32'(fc_a), 32'd3);
        check("t2_no_bubble", 32'(tot), 32'd26);
        sa.tvalid = 1'b0;
        @(posedge aclk);
        #1;

        // Downstream backpressure in payload phase, then during the trailer.
        ma.tready = 1'b0;
        send_a(good_f[0], cyc);
        sa.tdata = good_f[1];
        check("t5_fill_sready", 32'(sa.tready), 32'd0);
        repeat (10) begin
            @(posedge aclk);
            #1;
        end
        check("t5_stall_sready", 32'(sa.tready), 32'd0);
        check("t5_stall_valid", 32'(ma.tvalid), 32'd1);
        check("t5_stall_data", 32'(ma.tdata), 32'h31);
        ma.tready = 1'b1;
        for (int i = 1; i < 9; i++) send_a(good_f[i], cyc);
        check("t5_last_payload", 32'(ma.tdata), 32'h39);
        ma.tready = 1'b0;
        tot = 0;
        for (int i = 9; i < 13; i++) begin
            send_a(good_f[i], cyc);
            tot += cyc;
        end
        check("t5_trailer_cycles", 32'(tot), 32'd4);
        check("t5_cv", 32'(cv_a), 32'd1);
        check("t5_err", 32'(err_a), 32'd0);
        check("t5_fc", 32'(fc_a), 32'd4);
        check("t5_out_held_valid", 32'(ma.tvalid), 32'd1);
        check("t5_out_held_data", 32'(ma.tdata), 32'h39);
        sa.tvalid = 1'b0;
        ma.tready = 1'b1;
        @(posedge aclk);
        #1;
        check("t5_drained", 32'(ma.tvalid), 32'd0);

        // Frame counter wrap from a preloaded 0xFFFF.
        force dut_a.frame_cnt_q = 16'hFFFF;
        @(posedge aclk);
        #1;
        release dut_a.frame_cnt_q;
        @(posedge aclk);
        #1;
        check("t6_preload", 32'(fc_a), 32'h0000_FFFF);
        send_frame_a(bad_f, 1'b1, cyc);
        check("t6_cv", 32'(cv_a), 32'd1);
        check("t6_wrap", 32'(fc_a), 32'd0);
        check("t6_err", 32'(err_a), 32'd1);
        sa.tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("t6_err_held", 32'(err_a), 32'd1);
        send_frame_a(bad_f, 1'b1, cyc);
        check("t6_fc_after_wrap", 32'(fc_a), 32'd1);
        sa.tvalid = 1'b0;
        @(posedge aclk);
        #1;

        // Asynchronous reset after payload beat 2, then a full clean frame.
        for (int i = 0; i < 3; i++) send_a(good_f[i], cyc);
        sa.tvalid = 1'b0;
        rst_a = 1'b1;
        #1;
        check("t4_rst_tvalid", 32'(ma.tvalid), 32'd0);
        check("t4_rst_tdata", 32'(ma.tdata), 32'd0);
        check("t4_rst_cv", 32'(cv_a), 32'd0);
        check("t4_rst_err", 32'(err_a), 32'd0);
        check("t4_rst_fc", 32'(fc_a), 32'd0);
        check("t4_rst_sready", 32'(sa.tready), 32'd1);
        @(posedge aclk);
        #1;
        rst_a = 1'b0;
        @(posedge aclk);
        #1;
        send_frame_a(good_f, 1'b1, cyc);
        check("t4_cv", 32'(cv_a), 32'd1);
        check("t4_err", 32'(err_a), 32'd0);
        check("t4_fc", 32'(fc_a), 32'd1);
        sa.tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_cv_total", 32'(cv_cnt_a), 32'd7);

        // Word-wide instance: 100 random frames with input gaps and output stalls.
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = $urandom;
                exp_b.push_back(w[k]);
            end
            crc = crc_model(w);
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    sb.tvalid = 1'b0;
                    repeat ($urandom_range(1, 2)) @(posedge aclk);
                    #1;
                end
                send_b((k < 4) ? w[k] : crc);
            end
        end
        sb.tvalid = 1'b0;
        for (int t = 0; t < 300 && (cv_cnt_b < 100 || qb_out.size() < 400); t++) begin
            @(posedge aclk);
            #1;
        end
        rand_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("b_out_count", 32'(qb_out.size()), 32'd400);
        for (int k = 0; k < 400 && k < qb_out.size(); k++) begin
            check("b_out_data", qb_out[k], exp_b[k]);
        end
        check("b_cv_count", 32'(cv_cnt_b), 32'd100);
        check("b_err_frames", 32'(err_cnt_b), 32'd0);
        check("b_fc", 32'(fc_b), 32'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
